// File: rtl/sequencer.sv
// Instruction sequencer: fetches one opcode per instruction, decodes bus strobes
// from the latched instruction, and handles external input/output handshakes.
module sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            res,
  input  logic            run,
  input  logic [7:0]      opcode,
  input  logic            judge_val,
  input  logic [7:0]      reg0_val,
  input  logic            in_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] pc,
  output logic [7:0]      ir,
  output logic [5:0]      reg_load_en,
  output logic [5:0]      reg_save_en,
  output logic            imm_drive,
  output logic            alu_drive,
  output logic            cond_eval,
  output logic            in_read,
  output logic            out_write,
  output logic            halted
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WAIT_IN, WAIT_OUT, HALT} state_t;

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [7:0]      ir_reg, ir_next;
  logic [PC_W-1:0] jump_target;

  logic [2:0] src, dst;
  logic [5:0] src_hit, dst_hit;
  logic       src_ext, dst_ext, copy_bad, copy_go;
  logic       complete, take_jump;

  assign src         = ir_reg[5:3];
  assign dst         = ir_reg[2:0];
  assign src_ext     = (src == 3'd6);
  assign dst_ext     = (dst == 3'd6);
  assign copy_bad    = (src == 3'd7) || (dst == 3'd7);
  // A copy completes only once every external party it touches is ready.
  assign copy_go     = (!src_ext || in_valid) && (!dst_ext || out_ready);
  assign jump_target = PC_W'(reg0_val);

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_reg_sel
      assign src_hit[gi] = (src == 3'(gi));
      assign dst_hit[gi] = (dst == 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    ir_next     = ir_reg;
    reg_load_en = '0;
    reg_save_en = '0;
    imm_drive   = 1'b0;
    alu_drive   = 1'b0;
    cond_eval   = 1'b0;
    in_read     = 1'b0;
    out_write   = 1'b0;
    complete    = 1'b0;
    take_jump   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (run) state_next = FETCH;
      end
      FETCH: begin
        ir_next    = opcode;
        state_next = EXEC;
      end
      EXEC, WAIT_IN, WAIT_OUT: begin
        case (ir_reg[7:6])
          2'b00: begin
            imm_drive   = 1'b1;
            reg_save_en = 6'b000001;
            complete    = 1'b1;
          end
          2'b01: begin
            reg_load_en = 6'b000110;
            alu_drive   = 1'b1;
            reg_save_en = 6'b001000;
            complete    = 1'b1;
          end
          2'b11: begin
            reg_load_en = 6'b001000;
            cond_eval   = 1'b1;
            take_jump   = judge_val;
            complete    = 1'b1;
          end
          default: begin
            if (copy_bad) begin
              state_next = HALT;
            end else if (copy_go) begin
              // src/dst code 6 never matches a register select, so no masking needed.
              reg_load_en = src_hit;
              reg_save_en = dst_hit;
              in_read     = src_ext;
              out_write   = dst_ext;
              complete    = 1'b1;
            end else begin
              state_next = src_ext ? WAIT_IN : WAIT_OUT;
            end
          end
        endcase

        if (complete) begin
          pc_next    = take_jump ? jump_target : pc_reg + PC_W'(1);
          state_next = run ? FETCH : IDLE;
        end
      end
      HALT: state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  assign pc     = pc_reg;
  assign ir     = ir_reg;
  assign halted = (state_reg == HALT);

endmodule
